rf_writeback_arbiter: RTL and testbench

//   Shares the single register-file write port between three writeback sources:
//   ALU, MEM (load data) and MUL (16x16 product: low half to a destination register,

---
 rtl/rf_writeback_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU, MEM and MUL
// writeback sources; a MUL grant writes the low half, then the high half to HI_ADDR.
module rf_writeback_arbiter #(
  parameter int             DW      = 16,
  parameter int             AW      = 4,
  parameter logic [AW-1:0]  HI_ADDR = AW'(15)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          mul_valid,
  input  logic [AW-1:0] mul_addr,
  input  logic [DW-1:0] mul_lo,
  input  logic [DW-1:0] mul_hi,
  output logic          mul_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
);

  typedef enum logic {ARB, MUL_HI} state_t;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_MUL = 2'd2;

  state_t        state_reg, state_next;
  logic [1:0]    ptr_reg, ptr_next;
  logic [DW-1:0] hi_reg, hi_next;
  logic          wr_en_reg, wr_en_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [DW-1:0] wr_data_reg, wr_data_next;

  logic [2:0]    req_valid;
  logic [2:0]    grant;
  logic [1:0]    sel;
  logic          found;
  logic [1:0]    order_idx [3];

  assign req_valid = {mul_valid, mem_valid, alu_valid};

  // Requester examined in position gi of this cycle's search, rotated by ptr.
  for (genvar gi = 0; gi < 3; gi++) begin : g_order
    assign order_idx[gi] = 2'((32'(ptr_reg) + gi) % 3);
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    hi_next      = hi_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    grant        = 3'b000;
    sel          = SRC_ALU;
    found        = 1'b0;

    if (state_reg == MUL_HI) begin
      wr_en_next   = 1'b1;
      wr_addr_next = HI_ADDR;
      wr_data_next = hi_reg;
      state_next   = ARB;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!found && req_valid[order_idx[i]]) begin
          found = 1'b1;
          sel   = order_idx[i];
        end
      end
    end

    if (found) begin
      grant[sel] = 1'b1;
      wr_en_next = 1'b1;
      ptr_next   = (sel == SRC_MUL) ? SRC_ALU : sel + 2'd1;
      case (sel)
        SRC_MEM: begin
          wr_addr_next = mem_addr;
          wr_data_next = mem_data;
        end
        SRC_MUL: begin
          wr_addr_next = mul_addr;
          wr_data_next = mul_lo;
          hi_next      = mul_hi;
          state_next   = MUL_HI;
        end
        default: begin
          wr_addr_next = alu_addr;
          wr_data_next = alu_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB;
      ptr_reg     <= SRC_ALU;
      hi_reg      <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      hi_reg      <= hi_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Grants are suppressed while reset is held so nothing is consumed then dropped.
  assign alu_ready = grant[SRC_ALU] & ~rst;
  assign mem_ready = grant[SRC_MEM] & ~rst;
  assign mul_ready = grant[SRC_MUL] & ~rst;

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign busy    = wr_en_reg | (state_reg == MUL_HI);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench: a reference model predicts grants and the write stream; a monitor
// checks every cycle's write port against the queued expectations.
module tb_rf_writeback_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 0, mem_valid = 0, mul_valid = 0;
  logic [AW-1:0] alu_addr = 0, mem_addr = 0, mul_addr = 0;
  logic [DW-1:0] alu_data = 0, mem_data = 0, mul_lo = 0, mul_hi = 0;
  logic          alu_ready, mem_ready, mul_ready;
  logic          wr_en, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  rf_writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .mul_valid(mul_valid), .mul_addr(mul_addr), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .mul_ready(mul_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            due;
  } wr_t;

  wr_t           expq[$];
  bit            exp_en[int];
  logic [DW-1:0] rf_model [16];
  int            total = 0, bad = 0, cyc = 0;
  bit            mon_en = 0, prev_rst = 0;
  int            m_ptr = 0;
  bit            m_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: each cycle the write port either carries the next queued write or is idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        wr_t e;
        e = expq.pop_front();
        total++;
        if (wr_en !== 1'b1 || wr_addr !== e.a || wr_data !== e.d) begin
          bad++;
          $display("FAIL write: got en=%b %0d/%h want en=1 %0d/%h (cycle %0d)",
                   wr_en, wr_addr, wr_data, e.a, e.d, cyc);
        end
        rf_model[e.a] = e.d;
        $display("write cycle %0d: r%0d <= %h", cyc, e.a, e.d);
      end else begin
        chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
      end
    end
  end

  // One cycle: inputs already set; settle, compare readys/busy with the model, advance it.
  task automatic step(output int g);
    logic [2:0] v, want_rdy;
    bit         was_gap;
    #2;
    v       = {mul_valid, mem_valid, alu_valid};
    was_gap = m_gap;
    g       = -1;
    if (prev_rst) begin
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
    end
    chk("busy", {31'd0, busy}, {31'd0, exp_en.exists(cyc) || was_gap});
    if (rst) begin
      while (expq.size() > 0 && expq[$].due >= cyc + 1) void'(expq.pop_back());
      exp_en.delete(cyc + 1);
      exp_en.delete(cyc + 2);
      m_ptr = 0;
      m_gap = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        int s;
        s = (m_ptr + i) % 3;
        if (g < 0 && v[s]) g = s;
      end
    end
    want_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("ready", 32'({mul_ready, mem_ready, alu_ready}), 32'(want_rdy));
    if (g == 0) expq.push_back('{alu_addr, alu_data, cyc + 1});
    if (g == 1) expq.push_back('{mem_addr, mem_data, cyc + 1});
    if (g == 2) begin
      expq.push_back('{mul_addr, mul_lo, cyc + 1});
      expq.push_back('{4'd15, mul_hi, cyc + 2});
      exp_en[cyc + 2] = 1;
      m_gap = 1;
    end
    if (g >= 0) begin
      exp_en[cyc + 1] = 1;
      m_ptr = (g + 1) % 3;
    end
    $display("cycle %0d: rst=%b valid=%b grant=%0d", cyc, rst, v, g);
    prev_rst = rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    int g;
    rst = 1;
    step(g);
    rst = 0;
  endtask

  task automatic idle(input int n);
    int g;
    alu_valid = 0; mem_valid = 0; mul_valid = 0;
    for (int i = 0; i < n; i++) step(g);
  endtask

  initial begin
    int g;
    int seq1 [5] = '{0, 1, 2, -1, 0};
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    @(negedge clk);
    mon_en = 1;
    do_reset();

    // 1: all three held valid
    alu_valid = 1; alu_addr = 1; alu_data = 16'h0101;
    mem_valid = 1; mem_addr = 4; mem_data = 16'h0404;
    mul_valid = 1; mul_addr = 2; mul_lo = 16'h0011; mul_hi = 16'h0022;
    for (int i = 0; i < 5; i++) begin
      step(g);
      chk("s1_grant", 32'(g), 32'(seq1[i]));
    end
    idle(3);
    chk("s1_r15", 32'(rf_model[15]), 32'h0022);

    // 2: ALU only, back-to-back
    do_reset();
    alu_valid = 1; alu_addr = 3; alu_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step(g);
      chk("s2_grant", 32'(g), 32'd0);
    end
    idle(2);

    // 3: single MUL
    mul_valid = 1; mul_addr = 5; mul_lo = 16'hBEEF; mul_hi = 16'h0001;
    step(g);
    chk("s3_grant", 32'(g), 32'd2);
    mul_valid = 0;
    idle(3);
    chk("s3_r15", 32'(rf_model[15]), 32'h0001);

    // 4: MUL low half targets R15 too
    mul_valid = 1; mul_addr = 15; mul_lo = 16'hAAAA; mul_hi = 16'h5555;
    step(g);
    mul_valid = 0;
    idle(3);
    chk("s4_r15", 32'(rf_model[15]), 32'h5555);

    // 5: reset during the MUL_HI cycle
    mul_valid = 1; mul_addr = 5; mul_lo = 16'hBEEF; mul_hi = 16'h0077;
    step(g);
    mul_valid = 0;
    do_reset();
    alu_valid = 1; mem_valid = 1; mul_valid = 1;
    step(g);
    chk("s5_first_grant", 32'(g), 32'd0);
    idle(3);
    chk("s5_r15_kept", 32'(rf_model[15]), 32'h5555);

    // 6: ALU and MEM contend
    do_reset();
    alu_valid = 1; alu_addr = 6; mem_valid = 1; mem_addr = 7;
    for (int i = 0; i < 10; i++) begin
      step(g);
      chk("s6_alternate", 32'(g), 32'(i % 2));
    end
    idle(2);

    // Random traffic: requests held until accepted, occasional reset
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid && $urandom_range(0, 1)) begin
        alu_valid = 1; alu_addr = AW'($urandom); alu_data = DW'($urandom);
      end
      if (!mem_valid && $urandom_range(0, 1)) begin
        mem_valid = 1; mem_addr = AW'($urandom); mem_data = DW'($urandom);
      end
      if (!mul_valid && $urandom_range(0, 2) == 0) begin
        mul_valid = 1; mul_addr = AW'($urandom); mul_lo = DW'($urandom); mul_hi = DW'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step(g);
      if (g == 0) alu_valid = 0;
      if (g == 1) mem_valid = 0;
      if (g == 2) mul_valid = 0;
    end
    rst = 0;
    idle(4);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
